// File: rtl/param_half_adder.sv
// Registered WIDTH-bit unsigned adder without carry-in. The combinational sum is
// built as an explicit ripple chain: a half-adder cell at bit 0 and full-adder
// cells above it. Sum and carry-out are registered once, so results appear one
// cycle after the operands are sampled and a new pair can be accepted every cycle.
module param_half_adder #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  // carry[i] is the carry into bit i; carry[WIDTH] is the carry-out of the chain.
  logic [WIDTH:1]   carry;
  logic [WIDTH-1:0] sum_comb;

  logic [WIDTH-1:0] s_d, s_q;
  logic             cout_d, cout_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i == 0) begin : g_half
      // No carry-in, so bit 0 only needs a half-adder cell.
      assign sum_comb[0] = a[0] ^ b[0];
      assign carry[1]    = a[0] & b[0];
    end else begin : g_full
      assign sum_comb[i] = a[i] ^ b[i] ^ carry[i];
      assign carry[i+1]  = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

  // Next-state: capture the ripple result; reset is applied in the register.
  always_comb begin
    s_d    = sum_comb;
    cout_d = carry[WIDTH];
  end

  // Result register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q    <= '0;
      cout_q <= 1'b0;
    end else begin
      s_q    <= s_d;
      cout_q <= cout_d;
    end
  end

  assign s    = s_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_param_half_adder.sv
// Bench for param_half_adder: a WIDTH=4 instance driven from a vector table,
// plus WIDTH=1 and WIDTH=8 instances run in lockstep. Expected results are pushed
// to a scoreboard queue when operands are driven and popped one edge later.
module tb_param_half_adder;

  logic       clk;
  logic       rst;
  logic [3:0] a4, b4, s4;
  logic       c4;
  logic       a1, b1, s1, c1;
  logic [7:0] a8, b8, s8;
  logic       c8;

  int unsigned n_total;
  int unsigned n_pass;

  typedef struct {
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] s;
    logic       c;
  } vec_t;

  typedef struct {
    logic [3:0] s4;
    logic       c4;
    logic       s1;
    logic       c1;
    logic [7:0] s8;
    logic       c8;
  } exp_t;

  exp_t sb[$];

  param_half_adder #(.WIDTH(4)) u_dut4 (
    .clk  (clk),
    .rst  (rst),
    .a    (a4),
    .b    (b4),
    .s    (s4),
    .cout (c4)
  );

  param_half_adder #(.WIDTH(1)) u_dut1 (
    .clk  (clk),
    .rst  (rst),
    .a    (a1),
    .b    (b1),
    .s    (s1),
    .cout (c1)
  );

  param_half_adder #(.WIDTH(8)) u_dut8 (
    .clk  (clk),
    .rst  (rst),
    .a    (a8),
    .b    (b8),
    .s    (s8),
    .cout (c8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got {cout,s}=%0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Drive one set of operands on all instances; w4 expectation comes from the caller,
  // w1/w8 expectations from a plain integer-add model.
  task automatic drive(input logic r, input logic [3:0] x4, input logic [3:0] y4,
                       input logic [3:0] es4, input logic ec4,
                       input logic x1, input logic y1,
                       input logic [7:0] x8, input logic [7:0] y8);
    exp_t       e;
    logic [1:0] sum1;
    logic [8:0] sum8;
    rst  = r;
    a4   = x4;
    b4   = y4;
    a1   = x1;
    b1   = y1;
    a8   = x8;
    b8   = y8;
    sum1 = {1'b0, x1} + {1'b0, y1};
    sum8 = {1'b0, x8} + {1'b0, y8};
    e.s4 = es4;
    e.c4 = ec4;
    e.s1 = r ? 1'b0 : sum1[0];
    e.c1 = r ? 1'b0 : sum1[1];
    e.s8 = r ? 8'h00 : sum8[7:0];
    e.c8 = r ? 1'b0 : sum8[8];
    sb.push_back(e);
  endtask

  // Advance one edge and compare the result due for the operands driven before it.
  task automatic tick(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_total++;
      $display("FAIL %s: scoreboard empty, got w4 {cout,s}=%0h expected an entry", tag, {c4, s4});
    end else begin
      e = sb.pop_front();
      check({tag, " w4"}, {4'b0, c4, s4}, {4'b0, e.c4, e.s4});
      check({tag, " w1"}, {7'b0, c1, s1}, {7'b0, e.c1, e.s1});
      check({tag, " w8"}, {c8, s8}, {e.c8, e.s8});
    end
  endtask

  vec_t vecs[20];

  initial begin
    logic [3:0] ra, rb;
    logic [4:0] rsum;
    logic       r1a, r1b;
    logic [7:0] r8a, r8b;

    n_total = 0;
    n_pass  = 0;

    vecs[0]  = '{1'b1, 4'hF, 4'hF, 4'h0, 1'b0};  // reset held, operands ignored
    vecs[1]  = '{1'b1, 4'hF, 4'hF, 4'h0, 1'b0};
    vecs[2]  = '{1'b0, 4'hF, 4'hF, 4'hE, 1'b1};  // first sum after release
    vecs[3]  = '{1'b0, 4'h0, 4'h0, 4'h0, 1'b0};
    vecs[4]  = '{1'b0, 4'h1, 4'h0, 4'h1, 1'b0};
    vecs[5]  = '{1'b0, 4'h0, 4'h1, 4'h1, 1'b0};
    vecs[6]  = '{1'b0, 4'h1, 4'h1, 4'h2, 1'b0};
    vecs[7]  = '{1'b0, 4'h2, 4'h0, 4'h2, 1'b0};
    vecs[8]  = '{1'b0, 4'h3, 4'h0, 4'h3, 1'b0};
    vecs[9]  = '{1'b0, 4'h4, 4'h1, 4'h5, 1'b0};
    vecs[10] = '{1'b0, 4'h7, 4'h3, 4'hA, 1'b0};
    vecs[11] = '{1'b0, 4'hF, 4'h1, 4'h0, 1'b1};
    vecs[12] = '{1'b0, 4'hF, 4'h2, 4'h1, 1'b1};
    vecs[13] = '{1'b0, 4'h1, 4'hF, 4'h0, 1'b1};
    vecs[14] = '{1'b0, 4'h6, 4'hF, 4'h5, 1'b1};
    vecs[15] = '{1'b0, 4'hF, 4'hF, 4'hE, 1'b1};
    vecs[16] = '{1'b0, 4'h7, 4'h3, 4'hA, 1'b0};
    vecs[17] = '{1'b1, 4'hF, 4'hF, 4'h0, 1'b0};  // mid-stream reset
    vecs[18] = '{1'b0, 4'h4, 4'h1, 4'h5, 1'b0};  // resume
    vecs[19] = '{1'b0, 4'hF, 4'hF, 4'hE, 1'b1};

    // Back-to-back: new operands every cycle, other widths get random operands.
    for (int i = 0; i < 20; i++) begin
      r1a = 1'($urandom_range(0, 1));
      r1b = 1'($urandom_range(0, 1));
      r8a = 8'($urandom_range(0, 255));
      r8b = 8'($urandom_range(0, 255));
      drive(vecs[i].rst, vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].c, r1a, r1b, r8a, r8b);
      tick($sformatf("vec%0d", i));
    end

    // Width corner cases: 1+1 on one bit, 8-bit wrap and no-carry full-ones.
    drive(1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1, 8'hFF, 8'h01);
    tick("w1_1p1_w8_ffp01");
    drive(1'b0, 4'h8, 4'h8, 4'h0, 1'b1, 1'b0, 1'b1, 8'h80, 8'h7F);
    tick("w8_80p7f");

    // Outputs must hold when operands stop changing.
    drive(1'b0, 4'h9, 4'h9, 4'h2, 1'b1, 1'b1, 1'b0, 8'hFF, 8'hFF);
    tick("hold0");
    drive(1'b0, 4'h9, 4'h9, 4'h2, 1'b1, 1'b1, 1'b0, 8'hFF, 8'hFF);
    tick("hold1");

    // Random sweep with occasional reset pulses.
    for (int i = 0; i < 60; i++) begin
      logic rr;
      rr   = ($urandom_range(0, 15) == 0);
      ra   = 4'($urandom_range(0, 15));
      rb   = 4'($urandom_range(0, 15));
      rsum = {1'b0, ra} + {1'b0, rb};
      r1a  = 1'($urandom_range(0, 1));
      r1b  = 1'($urandom_range(0, 1));
      r8a  = 8'($urandom_range(0, 255));
      r8b  = 8'($urandom_range(0, 255));
      drive(rr, ra, rb, rr ? 4'h0 : rsum[3:0], rr ? 1'b0 : rsum[4], r1a, r1b, r8a, r8b);
      tick($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
